field_burst_mux: RTL and testbench

FIELD_BURST_MUX -- requirements
Module: field_burst_mux

---
 rtl/field_burst_pkg.sv | 15 +
 rtl/field_select.sv | 24 ++
 rtl/field_burst_mux.sv | 113 +++++++++++
 tb/tb_field_burst_mux.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/field_burst_pkg.sv
// Shared types and helpers for the field burst multiplexer.
// Holds the FSM state encoding and the index wrap helper used by the burst counter.
package field_burst_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } burst_state_e;

    // Advances an index by one and wraps to zero after num-1, for any num.
    function automatic logic [31:0] wrap_inc(input logic [31:0] idx, input logic [31:0] num);
        return ((idx + 32'd1) >= num) ? 32'd0 : (idx + 32'd1);
    endfunction

endpackage

// File: rtl/field_select.sv
// Combinational field extractor: returns field i_idx of a packed word.
// Indices beyond the last field return zero.
module field_select
    import field_burst_pkg::*;
#(
    parameter int FIELD_W    = 3,
    parameter int NUM_FIELDS = 4,
    parameter int SEL_W      = 2
) (
    input  logic [FIELD_W*NUM_FIELDS-1:0] i_word,
    input  logic [SEL_W-1:0]              i_idx,
    output logic [FIELD_W-1:0]            o_field
);

    always_comb begin
        o_field = '0;
        for (int k = 0; k < NUM_FIELDS; k++) begin
            if (i_idx == SEL_W'(k)) begin
                o_field = i_word[k*FIELD_W +: FIELD_W];
            end
        end
    end

endmodule

// File: rtl/field_burst_mux.sv
// Captures a packed word on request and streams a wrapping run of its fields
// out one beat per downstream handshake, with flush and async reset abort.
module field_burst_mux
    import field_burst_pkg::*;
#(
    parameter int  FIELD_W    = 3,
    parameter int  NUM_FIELDS = 4,
    localparam int SEL_W      = $clog2(NUM_FIELDS)
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [FIELD_W*NUM_FIELDS-1:0] i_data,
    input  logic [SEL_W-1:0]              i_sel,
    input  logic [SEL_W-1:0]              i_len,
    input  logic                          i_flush,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [FIELD_W-1:0]            o_data,
    output logic [SEL_W-1:0]              o_idx,
    output logic                          o_last
);

    burst_state_e                  state_q, state_d;
    logic [SEL_W-1:0]              idx_q, idx_d;
    logic [SEL_W-1:0]              rem_q, rem_d;
    logic [FIELD_W*NUM_FIELDS-1:0] cap_q, cap_d;
    logic [FIELD_W-1:0]            out_q, out_d;

    logic                          accept;
    logic                          xfer;
    logic [SEL_W-1:0]              start_idx;
    logic [SEL_W-1:0]              start_len;
    logic [SEL_W-1:0]              idx_next;
    logic [FIELD_W*NUM_FIELDS-1:0] sel_word;
    logic [SEL_W-1:0]              sel_idx;
    logic [FIELD_W-1:0]            sel_field;

    assign accept    = (state_q == ST_IDLE) && i_valid;
    assign xfer      = (state_q == ST_BURST) && i_ready;
    assign start_idx = (32'(i_sel) >= 32'(NUM_FIELDS)) ? '0 : i_sel;
    assign start_len = (32'(i_len) >= 32'(NUM_FIELDS)) ? SEL_W'(NUM_FIELDS - 1) : i_len;
    assign idx_next  = SEL_W'(wrap_inc(32'(idx_q), 32'(NUM_FIELDS)));

    // The single selector serves both the accept cycle (live word) and later beats (captured word).
    assign sel_word  = accept ? i_data : cap_q;
    assign sel_idx   = accept ? start_idx : idx_next;

    field_select #(
        .FIELD_W    (FIELD_W),
        .NUM_FIELDS (NUM_FIELDS),
        .SEL_W      (SEL_W)
    ) u_field_select (
        .i_word  (sel_word),
        .i_idx   (sel_idx),
        .o_field (sel_field)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        cap_d   = cap_q;
        out_d   = out_q;
        if (state_q == ST_IDLE) begin
            if (accept) begin
                cap_d   = i_data;
                idx_d   = start_idx;
                rem_d   = start_len;
                out_d   = sel_field;
                state_d = ST_BURST;
            end
        end else begin
            if (xfer) begin
                if (rem_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    idx_d = idx_next;
                    rem_d = rem_q - SEL_W'(1);
                    out_d = sel_field;
                end
            end
            // A beat handshaken together with flush still counts as delivered.
            if (i_flush) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            rem_q   <= '0;
            cap_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            cap_q   <= cap_d;
            out_q   <= out_d;
        end
    end

    assign o_ready = (state_q == ST_IDLE);
    assign o_valid = (state_q == ST_BURST);
    assign o_data  = out_q;
    assign o_idx   = idx_q;
    assign o_last  = (state_q == ST_BURST) && (rem_q == '0);

endmodule

// File: tb/tb_field_burst_mux.sv
// Randomised self-checking bench for field_burst_mux: a 3x4 instance and a 4x5 instance
// checked against a queue-based beat model built from the burst rules.
module tb_field_burst_mux;

    localparam logic [31:0] STD_DATA = 32'b101_011_110_001;

    logic        clk;
    logic        rst_n;

    logic        a_valid, a_ready, a_flush, a_ovalid, a_iready, a_olast;
    logic [11:0] a_data;
    logic [1:0]  a_sel, a_len, a_oidx;
    logic [2:0]  a_odata;

    logic        b_valid, b_ready, b_flush, b_ovalid, b_iready, b_olast;
    logic [19:0] b_data;
    logic [2:0]  b_sel, b_len, b_oidx;
    logic [3:0]  b_odata;

    int pass_cnt;
    int total_cnt;

    field_burst_mux #(.FIELD_W(3), .NUM_FIELDS(4)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (a_valid),
        .o_ready (a_ready),
        .i_data  (a_data),
        .i_sel   (a_sel),
        .i_len   (a_len),
        .i_flush (a_flush),
        .o_valid (a_ovalid),
        .i_ready (a_iready),
        .o_data  (a_odata),
        .o_idx   (a_oidx),
        .o_last  (a_olast)
    );

    field_burst_mux #(.FIELD_W(4), .NUM_FIELDS(5)) dut5 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (b_valid),
        .o_ready (b_ready),
        .i_data  (b_data),
        .i_sel   (b_sel),
        .i_len   (b_len),
        .i_flush (b_flush),
        .o_valid (b_ovalid),
        .i_ready (b_iready),
        .o_data  (b_odata),
        .o_idx   (b_oidx),
        .o_last  (b_olast)
    );

    always #5 clk = ~clk;

    task automatic set_req(input int which, input logic v, input logic [31:0] data,
                           input logic [31:0] sel, input logic [31:0] len);
        if (which == 0) begin
            a_valid = v; a_data = data[11:0]; a_sel = sel[1:0]; a_len = len[1:0];
        end else begin
            b_valid = v; b_data = data[19:0]; b_sel = sel[2:0]; b_len = len[2:0];
        end
    endtask

    task automatic set_ctl(input int which, input logic rdy, input logic fl);
        if (which == 0) begin
            a_iready = rdy; a_flush = fl;
        end else begin
            b_iready = rdy; b_flush = fl;
        end
    endtask

    task automatic get_obs(input int which, output logic ov, output logic orr,
                           output logic [31:0] od, output logic [31:0] oi, output logic ol);
        if (which == 0) begin
            ov = a_ovalid; orr = a_ready; od = 32'(a_odata); oi = 32'(a_oidx); ol = a_olast;
        end else begin
            ov = b_ovalid; orr = b_ready; od = 32'(b_odata); oi = 32'(b_oidx); ol = b_olast;
        end
    endtask

    // Issues one request, then walks it beat by beat against the expected field sequence.
    task automatic run_burst(input int which, input logic [31:0] data, input int sel, input int len,
                             input int rand_ready, input int stall_beat, input int stall_cycles,
                             input int flush_beat, input string tag);
        int n, fw, sel_c, len_c, beat, stalls, cycles, expect_beats;
        int exp_idx[$];
        logic [31:0] exp_data[$];
        logic ov, orr, ol, rdy, fl;
        logic [31:0] od, oi;
        n     = (which == 0) ? 4 : 5;
        fw    = (which == 0) ? 3 : 4;
        sel_c = (sel >= n) ? 0 : sel;
        len_c = (len >= n) ? n - 1 : len;
        for (int b = 0; b <= len_c; b++) begin
            exp_idx.push_back((sel_c + b) % n);
            exp_data.push_back((data >> (((sel_c + b) % n) * fw)) & ((32'd1 << fw) - 32'd1));
        end
        expect_beats = (flush_beat >= 0 && flush_beat <= len_c) ? flush_beat + 1 : len_c + 1;

        get_obs(which, ov, orr, od, oi, ol);
        total_cnt++;
        if (orr !== 1'b1 || ov !== 1'b0)
            $display("[TB] FAIL %s idle_before: ready=%0b valid=%0b, expected ready=1 valid=0", tag, orr, ov);
        else
            pass_cnt++;

        set_req(which, 1'b1, data, 32'(sel), 32'(len));
        set_ctl(which, 1'b0, 1'b0);
        @(posedge clk); #1;
        set_req(which, 1'b0, $urandom, $urandom, $urandom);

        beat = 0; stalls = 0; cycles = 0;
        while (beat < expect_beats) begin
            if (cycles >= 200) begin
                total_cnt++;
                $display("[TB] FAIL %s timeout: delivered %0d beats, expected %0d", tag, beat, expect_beats);
                break;
            end
            get_obs(which, ov, orr, od, oi, ol);
            total_cnt++;
            if (ov !== 1'b1 || orr !== 1'b0 || od !== exp_data[beat] || oi !== 32'(exp_idx[beat])
                || ol !== (beat == len_c))
                $display("[TB] FAIL %s beat%0d: valid=%0b ready=%0b data=%0h idx=%0d last=%0b, expected valid=1 ready=0 data=%0h idx=%0d last=%0b",
                         tag, beat, ov, orr, od, oi, ol, exp_data[beat], exp_idx[beat], (beat == len_c));
            else
                pass_cnt++;
            fl = (beat == flush_beat);
            if (fl)
                rdy = 1'b1;
            else if (rand_ready != 0)
                rdy = 1'($urandom_range(0, 1));
            else if (beat == stall_beat && stalls < stall_cycles) begin
                rdy = 1'b0;
                stalls++;
            end else
                rdy = 1'b1;
            set_ctl(which, rdy, fl);
            @(posedge clk); #1;
            cycles++;
            set_ctl(which, 1'b0, 1'b0);
            set_req(which, 1'b0, $urandom, $urandom, $urandom);
            if (rdy) beat++;
            if (fl) break;
        end

        get_obs(which, ov, orr, od, oi, ol);
        total_cnt++;
        if (ov !== 1'b0 || orr !== 1'b1 || beat !== expect_beats)
            $display("[TB] FAIL %s end: valid=%0b ready=%0b beats=%0d, expected valid=0 ready=1 beats=%0d",
                     tag, ov, orr, beat, expect_beats);
        else
            pass_cnt++;
    endtask

    task automatic test_reset();
        logic ov, orr, ol;
        logic [31:0] od, oi;
        #3;
        for (int w = 0; w < 2; w++) begin
            get_obs(w, ov, orr, od, oi, ol);
            total_cnt++;
            if (ov !== 1'b0 || orr !== 1'b1 || od !== 32'd0 || oi !== 32'd0 || ol !== 1'b0)
                $display("[TB] FAIL reset%0d: valid=%0b ready=%0b data=%0h idx=%0d last=%0b, expected 0 1 0 0 0",
                         w, ov, orr, od, oi, ol);
            else
                pass_cnt++;
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        run_burst(0, STD_DATA, 2, 0, 0, -1, 0, -1, "single");
    endtask

    task automatic test_wrap();
        run_burst(0, STD_DATA, 3, 3, 0, -1, 0, -1, "wrap");
    endtask

    task automatic test_backpressure();
        run_burst(0, STD_DATA, 3, 3, 0, 1, 3, -1, "backpressure");
    endtask

    task automatic test_flush();
        run_burst(0, STD_DATA, 3, 3, 0, -1, 0, 1, "flush");
    endtask

    task automatic test_flush_idle();
        logic ov, orr, ol;
        logic [31:0] od, oi;
        set_ctl(0, 1'b1, 1'b1);
        set_req(0, 1'b1, STD_DATA, 32'd1, 32'd0);
        @(posedge clk); #1;
        set_req(0, 1'b0, 32'd0, 32'd0, 32'd0);
        set_ctl(0, 1'b0, 1'b0);
        get_obs(0, ov, orr, od, oi, ol);
        total_cnt++;
        if (ov !== 1'b1 || od !== 32'b110 || oi !== 32'd1 || ol !== 1'b1)
            $display("[TB] FAIL flush_idle: valid=%0b data=%0h idx=%0d last=%0b, expected valid=1 data=6 idx=1 last=1",
                     ov, od, oi, ol);
        else
            pass_cnt++;
        set_ctl(0, 1'b1, 1'b0);
        @(posedge clk); #1;
        set_ctl(0, 1'b0, 1'b0);
        get_obs(0, ov, orr, od, oi, ol);
        total_cnt++;
        if (ov !== 1'b0 || orr !== 1'b1)
            $display("[TB] FAIL flush_idle_end: valid=%0b ready=%0b, expected valid=0 ready=1", ov, orr);
        else
            pass_cnt++;
    endtask

    task automatic test_reset_mid_burst();
        logic ov, orr, ol;
        logic [31:0] od, oi;
        set_req(0, 1'b1, STD_DATA, 32'd3, 32'd3);
        set_ctl(0, 1'b0, 1'b0);
        @(posedge clk); #1;
        set_req(0, 1'b0, 32'd0, 32'd0, 32'd0);
        set_ctl(0, 1'b1, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        set_ctl(0, 1'b0, 1'b0);
        get_obs(0, ov, orr, od, oi, ol);
        total_cnt++;
        if (ov !== 1'b1 || od !== 32'b110 || oi !== 32'd1)
            $display("[TB] FAIL pre_reset_beat3: valid=%0b data=%0h idx=%0d, expected valid=1 data=6 idx=1", ov, od, oi);
        else
            pass_cnt++;
        rst_n = 1'b0;
        #1;
        get_obs(0, ov, orr, od, oi, ol);
        total_cnt++;
        if (ov !== 1'b0 || orr !== 1'b1 || od !== 32'd0 || oi !== 32'd0 || ol !== 1'b0)
            $display("[TB] FAIL async_reset: valid=%0b ready=%0b data=%0h idx=%0d last=%0b, expected 0 1 0 0 0",
                     ov, orr, od, oi, ol);
        else
            pass_cnt++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_burst(0, STD_DATA, 1, 2, 0, -1, 0, -1, "after_reset");
    endtask

    task automatic test_nonpow2();
        run_burst(1, $urandom, 4, 1, 0, -1, 0, -1, "np2_wrap");
        run_burst(1, $urandom, 6, 0, 0, -1, 0, -1, "np2_sel_clamp");
        run_burst(1, $urandom, 0, 7, 0, -1, 0, -1, "np2_len_clamp");
        run_burst(1, $urandom, 2, 7, 1, -1, 0, -1, "np2_rand_ready");
    endtask

    task automatic test_random();
        int fb;
        for (int i = 0; i < 12; i++) begin
            for (int w = 0; w < 2; w++) begin
                fb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1;
                run_burst(w, $urandom, int'($urandom_range(0, (w == 0) ? 3 : 7)),
                          int'($urandom_range(0, (w == 0) ? 3 : 7)), 1, -1, 0, fb, "random");
            end
        end
    endtask

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        pass_cnt = 0;
        total_cnt = 0;
        set_req(0, 1'b0, 32'd0, 32'd0, 32'd0);
        set_req(1, 1'b0, 32'd0, 32'd0, 32'd0);
        set_ctl(0, 1'b0, 1'b0);
        set_ctl(1, 1'b0, 1'b0);
        test_reset();
        test_single();
        test_wrap();
        test_backpressure();
        test_flush();
        test_flush_idle();
        test_reset_mid_burst();
        test_nonpow2();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
